// File: rtl/pipe_pkg.sv
// Shared types and defaults for the pipeline stage registers.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } stage_state_t;

  localparam int unsigned PIPE_PC_W    = 32;
  localparam int unsigned PIPE_INSTR_W = 32;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR_RV = 32'h0000_0013;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter: increments on inc_i, sticks at all-ones, cleared only by reset.
module pipe_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [CNT_W-1:0] value_o
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      value_o <= '0;
    end else if (inc_i && (value_o != '1)) begin
      value_o <= value_o + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// {pc, instr} pipeline stage register with valid/ready handshake, stall, flush and 2-entry skid.
// Optional perf counters (stall_cnt_o, flush_cnt_o) are built when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned        PC_W      = PIPE_PC_W,
  parameter int unsigned        INSTR_W   = PIPE_INSTR_W,
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_RV,
  parameter int unsigned        CNT_W     = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic               flush_i,
  input  logic               stall_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [PC_W-1:0]    pc_i,
  input  logic [INSTR_W-1:0] instr_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [PC_W-1:0]    pc_o,
  output logic [INSTR_W-1:0] instr_o
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]   stall_cnt_o,
  output logic [CNT_W-1:0]   flush_cnt_o
`endif
);

  if (CNT_W == 0 || CNT_W > 64) begin : g_cnt_w_check
    $error("pipe_stage_reg: CNT_W out of range");
  end

  stage_state_t       state_q, state_d;
  logic [PC_W-1:0]    skid_pc_q;
  logic [INSTR_W-1:0] skid_instr_q;
  logic               in_ready_q;
  logic               accept;
  logic               rel;

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = (state_q != EMPTY);
  assign accept      = in_valid_i & in_ready_q & start_i;
  assign rel         = out_valid_o & out_ready_i & ~stall_i;

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY:   if (accept) state_d = HALF;
        HALF: begin
          if (accept && !rel)      state_d = FULL;
          else if (!accept && rel) state_d = EMPTY;
        end
        FULL:    if (rel) state_d = HALF;
        default: state_d = EMPTY;
      endcase
    end
  end

  // Ready is derived from the next state so it is already low in the cycle FULL is entered.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= EMPTY;
      in_ready_q   <= 1'b0;
      pc_o         <= '0;
      instr_o      <= NOP_INSTR;
      skid_pc_q    <= '0;
      skid_instr_q <= NOP_INSTR;
    end else begin
      state_q    <= state_d;
      in_ready_q <= start_i & (state_d != FULL);
      if (flush_i) begin
        instr_o <= NOP_INSTR;
      end else begin
        unique case (state_q)
          EMPTY: begin
            if (accept) begin
              pc_o    <= pc_i;
              instr_o <= instr_i;
            end
          end
          HALF: begin
            if (accept && rel) begin
              pc_o    <= pc_i;
              instr_o <= instr_i;
            end else if (accept) begin
              skid_pc_q    <= pc_i;
              skid_instr_q <= instr_i;
            end
          end
          FULL: begin
            if (rel) begin
              pc_o    <= skid_pc_q;
              instr_o <= skid_instr_q;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic stall_inc;
  logic flush_inc;

  assign stall_inc = out_valid_o & (stall_i | ~out_ready_i);
  assign flush_inc = flush_i & out_valid_o;

  pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc_i   (stall_inc),
    .value_o (stall_cnt_o)
  );

  pipe_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc_i   (flush_inc),
    .value_o (flush_cnt_o)
  );
`endif

endmodule
